// File: rtl/arcade_input_map.sv
// Arcade control mapper: PS/2 key latches OR'd with joysticks, SOCD cleaning,
// and per-player coin pulse stretchers with optional active-low outputs.
module arcade_input_map #(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter logic [15:0] COIN_PULSE   = 16'd50000,
  parameter int unsigned SOCD_NEUTRAL = 1,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic                        clk_sys,
  input  logic                        RESET,
  input  logic [10:0]                 ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]   joy,
  output logic [4*NUM_PLAYERS-1:0]    dir_o,
  output logic [NUM_PLAYERS-1:0]      start_o,
  output logic [NUM_PLAYERS-1:0]      coin_o
);

  localparam int          NP         = int'(NUM_PLAYERS);
  localparam logic        SOCD_EN    = (SOCD_NEUTRAL != 0);
  localparam logic        OUT_INV    = (ACTIVE_LOW != 0);
  localparam logic [15:0] PULSE_LOAD = COIN_PULSE - 16'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLD} coin_st_e;

  // Key latch bit order matches joy: 0 right, 1 left, 2 down, 3 up, 4 coin, 5 start.
  function automatic logic key_hit(input int p, input int b, input logic [8:0] code);
    logic hit;
    hit = 1'b0;
    case (b)
      0: hit = (p == 0 && code == 9'h174) || (p == 1 && code == 9'h034);
      1: hit = (p == 0 && code == 9'h16B) || (p == 1 && code == 9'h023);
      2: hit = (p == 0 && code == 9'h172) || (p == 1 && code == 9'h02B);
      3: hit = (p == 0 && code == 9'h175) || (p == 1 && code == 9'h02D);
      4: hit = (p == 0 && (code == 9'h02E || code == 9'h029)) ||
               (p == 1 && (code == 9'h036 || code == 9'h014)) ||
               (p == 2 && code == 9'h03D) || (p == 3 && code == 9'h03E);
      5: hit = (p == 0 && (code == 9'h016 || code == 9'h005)) ||
               (p == 1 && (code == 9'h01E || code == 9'h006)) ||
               (p == 2 && code == 9'h026) || (p == 3 && code == 9'h025);
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  logic                 tog_q;
  logic                 key_evt_c;
  logic [5:0]           key_q [NP];
  logic [5:0]           key_d [NP];
  logic [6*NP-1:0]      raw_c;
  logic [4*NP-1:0]      dir_c;
  logic [NP-1:0]        start_c;
  logic [NP-1:0]        coin_raw_c;
  logic [NP-1:0]        coin_prev_q;
  logic [NP-1:0]        coin_act_c;
  logic                 joy_unused_c;
  coin_st_e             st_q  [NP];
  coin_st_e             st_d  [NP];
  logic [15:0]          cnt_q [NP];
  logic [15:0]          cnt_d [NP];
  logic [4*NP-1:0]      dir_q;
  logic [NP-1:0]        start_q;
  logic [NP-1:0]        coin_q;

  assign key_evt_c = ps2_key[10] ^ tog_q;

  // Key latches: only existing players are scanned, so other codes fall through.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      key_d[p] = key_q[p];
      for (int b = 0; b < 6; b++) begin
        if (key_evt_c && key_hit(p, b, ps2_key[8:0])) key_d[p][b] = ps2_key[9];
      end
    end
  end

  always_comb begin
    raw_c        = '0;
    dir_c        = '0;
    start_c      = '0;
    coin_raw_c   = '0;
    joy_unused_c = 1'b0;
    for (int p = 0; p < NP; p++) begin
      raw_c[6*p +: 6] = key_q[p] | joy[16*p +: 6];
      joy_unused_c    = joy_unused_c ^ (^joy[16*p+6 +: 10]);
      dir_c[4*p+0]    = raw_c[6*p+0] & ~(SOCD_EN & raw_c[6*p+1]);
      dir_c[4*p+1]    = raw_c[6*p+1] & ~(SOCD_EN & raw_c[6*p+0]);
      dir_c[4*p+2]    = raw_c[6*p+2] & ~(SOCD_EN & raw_c[6*p+3]);
      dir_c[4*p+3]    = raw_c[6*p+3] & ~(SOCD_EN & raw_c[6*p+2]);
      start_c[p]      = raw_c[6*p+5];
      coin_raw_c[p]   = raw_c[6*p+4];
    end
  end

  // Coin stretcher: one pulse per rising edge, no retrigger, held coin parks in HOLD.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      st_d[p]       = st_q[p];
      cnt_d[p]      = cnt_q[p];
      coin_act_c[p] = 1'b0;
      case (st_q[p])
        ST_IDLE: begin
          if (coin_raw_c[p] && !coin_prev_q[p]) begin
            st_d[p]  = ST_PULSE;
            cnt_d[p] = PULSE_LOAD;
          end
        end
        ST_PULSE: begin
          if (cnt_q[p] == 16'd0) st_d[p] = coin_raw_c[p] ? ST_HOLD : ST_IDLE;
          else                   cnt_d[p] = cnt_q[p] - 16'd1;
        end
        ST_HOLD: begin
          if (!coin_raw_c[p]) st_d[p] = ST_IDLE;
        end
        default: st_d[p] = ST_IDLE;
      endcase
      coin_act_c[p] = (st_d[p] == ST_PULSE);
    end
  end

  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_key[10];
    if (RESET) begin
      coin_prev_q <= '0;
      dir_q       <= {(4*NP){OUT_INV}};
      start_q     <= {NP{OUT_INV}};
      coin_q      <= {NP{OUT_INV}};
      for (int p = 0; p < NP; p++) begin
        key_q[p] <= '0;
        st_q[p]  <= ST_IDLE;
        cnt_q[p] <= '0;
      end
    end else begin
      coin_prev_q <= coin_raw_c;
      dir_q       <= dir_c ^ {(4*NP){OUT_INV}};
      start_q     <= start_c ^ {NP{OUT_INV}};
      coin_q      <= coin_act_c ^ {NP{OUT_INV}};
      for (int p = 0; p < NP; p++) begin
        key_q[p] <= key_d[p];
        st_q[p]  <= st_d[p];
        cnt_q[p] <= cnt_d[p];
      end
    end
  end

  assign dir_o   = dir_q;
  assign start_o = start_q;
  assign coin_o  = coin_q;

endmodule

// File: tb/tb_arcade_input_map.sv
// Directed bench for arcade_input_map: three instances differing in SOCD and output polarity.
module tb_arcade_input_map;

  logic        clk_sys = 1'b0;
  logic        RESET;
  logic [10:0] ps2_key;
  logic [31:0] joy;
  logic [7:0]  dir_a, dir_b, dir_c;
  logic [1:0]  start_a, start_b, start_c;
  logic [1:0]  coin_a, coin_b, coin_c;
  int          checks = 0;
  int          errors = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_map #(.NUM_PLAYERS(2), .COIN_PULSE(16'd5), .SOCD_NEUTRAL(1), .ACTIVE_LOW(0)) dut_a (
    .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key), .joy(joy),
    .dir_o(dir_a), .start_o(start_a), .coin_o(coin_a));

  arcade_input_map #(.NUM_PLAYERS(2), .COIN_PULSE(16'd5), .SOCD_NEUTRAL(0), .ACTIVE_LOW(0)) dut_b (
    .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key), .joy(joy),
    .dir_o(dir_b), .start_o(start_b), .coin_o(coin_b));

  arcade_input_map #(.NUM_PLAYERS(2), .COIN_PULSE(16'd5), .SOCD_NEUTRAL(1), .ACTIVE_LOW(1)) dut_c (
    .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key), .joy(joy),
    .dir_o(dir_c), .start_o(start_c), .coin_o(coin_c));

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_key(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    ps2_key = {1'b1, 1'b1, 9'h175};
    joy = '0;
    tick(); tick(); tick();
    checks++;
    if ({dir_a, start_a, coin_a} !== 12'h000) begin
      errors++; $display("FAIL reset_low_outputs: got %h expected %h", {dir_a, start_a, coin_a}, 12'h000);
    end
    checks++;
    if ({dir_c, start_c, coin_c} !== 12'hFFF) begin
      errors++; $display("FAIL reset_high_outputs: got %h expected %h", {dir_c, start_c, coin_c}, 12'hFFF);
    end
    RESET = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({dir_a, start_a, coin_a} !== 12'h000) begin
      errors++; $display("FAIL no_spurious_event: got %h expected %h", {dir_a, start_a, coin_a}, 12'h000);
    end
    checks++;
    if ({dir_c, start_c, coin_c} !== 12'hFFF) begin
      errors++; $display("FAIL idle_active_low: got %h expected %h", {dir_c, start_c, coin_c}, 12'hFFF);
    end
  endtask

  task automatic test_key_dir();
    send_key(1'b1, 9'h175);
    tick();
    checks++;
    if (dir_a !== 8'h00) begin
      errors++; $display("FAIL key_latency_early: got %h expected %h", dir_a, 8'h00);
    end
    tick();
    checks++;
    if (dir_a !== 8'h08) begin
      errors++; $display("FAIL key_up_press: got %h expected %h", dir_a, 8'h08);
    end
    checks++;
    if (dir_c !== 8'hF7) begin
      errors++; $display("FAIL key_up_active_low: got %h expected %h", dir_c, 8'hF7);
    end
    ps2_key[9] = 1'b0;
    tick(); tick();
    checks++;
    if (dir_a !== 8'h08) begin
      errors++; $display("FAIL no_toggle_no_change: got %h expected %h", dir_a, 8'h08);
    end
    send_key(1'b0, 9'h175);
    tick();
    checks++;
    if (dir_a !== 8'h08) begin
      errors++; $display("FAIL release_latency_early: got %h expected %h", dir_a, 8'h08);
    end
    tick();
    checks++;
    if (dir_a !== 8'h00) begin
      errors++; $display("FAIL key_up_release: got %h expected %h", dir_a, 8'h00);
    end
    send_key(1'b1, 9'h023);
    tick(); tick();
    checks++;
    if (dir_a !== 8'h20) begin
      errors++; $display("FAIL p2_left_key: got %h expected %h", dir_a, 8'h20);
    end
    send_key(1'b0, 9'h023);
    tick(); tick();
    checks++;
    if (dir_a !== 8'h00) begin
      errors++; $display("FAIL p2_left_release: got %h expected %h", dir_a, 8'h00);
    end
  endtask

  task automatic test_socd();
    joy = 32'h0000_0003;
    tick();
    checks++;
    if (dir_a[3:0] !== 4'b0000) begin
      errors++; $display("FAIL socd_lr_neutral: got %b expected %b", dir_a[3:0], 4'b0000);
    end
    checks++;
    if (dir_b[3:0] !== 4'b0011) begin
      errors++; $display("FAIL socd_lr_pass: got %b expected %b", dir_b[3:0], 4'b0011);
    end
    joy = 32'h0000_0002;
    tick();
    checks++;
    if (dir_a[3:0] !== 4'b0010 || dir_b[3:0] !== 4'b0010) begin
      errors++; $display("FAIL socd_release_right: got %b/%b expected %b", dir_a[3:0], dir_b[3:0], 4'b0010);
    end
    joy = 32'h0000_000E;
    tick();
    checks++;
    if (dir_a[3:0] !== 4'b0010 || dir_b[3:0] !== 4'b1110) begin
      errors++; $display("FAIL socd_axes_indep: got %b/%b expected %b/%b", dir_a[3:0], dir_b[3:0], 4'b0010, 4'b1110);
    end
    joy = 32'h000C_0001;
    tick();
    checks++;
    if (dir_a !== 8'h01 || dir_b !== 8'hC1) begin
      errors++; $display("FAIL socd_p2_ud: got %h/%h expected %h/%h", dir_a, dir_b, 8'h01, 8'hC1);
    end
    joy = 32'h0000_0002;
    send_key(1'b1, 9'h174);
    tick(); tick();
    checks++;
    if (dir_a !== 8'h00 || dir_b !== 8'h03) begin
      errors++; $display("FAIL socd_key_joy: got %h/%h expected %h/%h", dir_a, dir_b, 8'h00, 8'h03);
    end
    send_key(1'b0, 9'h174);
    joy = '0;
    tick(); tick();
  endtask

  task automatic test_start();
    joy = 32'h0020_0000;
    tick();
    checks++;
    if (start_a !== 2'b10 || start_c !== 2'b01) begin
      errors++; $display("FAIL start_joy_p2: got %b/%b expected %b/%b", start_a, start_c, 2'b10, 2'b01);
    end
    send_key(1'b1, 9'h005);
    tick(); tick();
    checks++;
    if (start_a !== 2'b11) begin
      errors++; $display("FAIL start_alias_p1: got %b expected %b", start_a, 2'b11);
    end
    send_key(1'b0, 9'h005);
    joy = '0;
    tick(); tick();
    checks++;
    if (start_a !== 2'b00) begin
      errors++; $display("FAIL start_release: got %b expected %b", start_a, 2'b00);
    end
  endtask

  task automatic test_coin_pulse();
    int cnt;
    int rises;
    logic prev;
    cnt = 0;
    joy = 32'h0000_0010;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if (coin_a !== 2'b01 || coin_c !== 2'b10) begin
          errors++; $display("FAIL coin_latency: got %b/%b expected %b/%b", coin_a, coin_c, 2'b01, 2'b10);
        end
      end
      if (coin_a[0]) cnt++;
      if (i == 1) joy = '0;
    end
    checks++;
    if (cnt != 5) begin
      errors++; $display("FAIL coin_short_len: got %0d expected %0d", cnt, 5);
    end
    cnt = 0; rises = 0; prev = 1'b0;
    joy = 32'h0000_0010;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (coin_a[0]) cnt++;
      if (coin_a[0] && !prev) rises++;
      prev = coin_a[0];
      if (i == 19) joy = '0;
    end
    checks++;
    if (cnt != 5 || rises != 1) begin
      errors++; $display("FAIL coin_held_single: got len %0d pulses %0d expected len 5 pulses 1", cnt, rises);
    end
    joy = 32'h0000_0010;
    tick();
    checks++;
    if (coin_a !== 2'b01) begin
      errors++; $display("FAIL coin_repress: got %b expected %b", coin_a, 2'b01);
    end
    joy = '0;
    repeat (8) tick();
  endtask

  task automatic test_no_retrigger();
    logic [9:0] pat;
    int cnt;
    pat = 10'b00_0000_0101;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      joy[4] = (i < 10) ? pat[i] : 1'b0;
      tick();
      if (coin_a[0]) cnt++;
    end
    checks++;
    if (cnt != 5) begin
      errors++; $display("FAIL coin_no_retrigger: got %0d expected %0d", cnt, 5);
    end
    joy = '0;
    tick();
  endtask

  task automatic test_key_coins();
    int f0, f1, c0, c1;
    send_key(1'b1, 9'h03D);
    tick(); tick(); tick();
    checks++;
    if ({dir_a, start_a, coin_a} !== 12'h000) begin
      errors++; $display("FAIL p3_coin_ignored: got %h expected %h", {dir_a, start_a, coin_a}, 12'h000);
    end
    f0 = -1; f1 = -1; c0 = 0; c1 = 0;
    send_key(1'b1, 9'h02E);
    for (int i = 0; i < 12; i++) begin
      if (i == 1) send_key(1'b1, 9'h036);
      tick();
      if (coin_a[0]) begin c0++; if (f0 < 0) f0 = i; end
      if (coin_a[1]) begin c1++; if (f1 < 0) f1 = i; end
    end
    checks++;
    if (f0 != 1 || f1 != 2) begin
      errors++; $display("FAIL key_coin_offset: got start %0d/%0d expected 1/2", f0, f1);
    end
    checks++;
    if (c0 != 5 || c1 != 5) begin
      errors++; $display("FAIL key_coin_len: got %0d/%0d expected 5/5", c0, c1);
    end
    send_key(1'b0, 9'h02E);
    tick();
    send_key(1'b0, 9'h036);
    repeat (5) tick();
    checks++;
    if (coin_a !== 2'b00) begin
      errors++; $display("FAIL key_coin_release: got %b expected %b", coin_a, 2'b00);
    end
    send_key(1'b1, 9'h014);
    tick(); tick();
    checks++;
    if (coin_a !== 2'b10) begin
      errors++; $display("FAIL coin_alias_p2: got %b expected %b", coin_a, 2'b10);
    end
    send_key(1'b0, 9'h014);
    repeat (8) tick();
  endtask

  task automatic test_simultaneous();
    joy = 32'h0010_0010;
    tick();
    checks++;
    if (coin_a !== 2'b11) begin
      errors++; $display("FAIL coin_simultaneous: got %b expected %b", coin_a, 2'b11);
    end
    joy = '0;
    repeat (8) tick();
    checks++;
    if (coin_a !== 2'b00) begin
      errors++; $display("FAIL coin_simul_end: got %b expected %b", coin_a, 2'b00);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int cnt;
    joy = 32'h0000_0010;
    tick(); tick();
    checks++;
    if (coin_c !== 2'b10) begin
      errors++; $display("FAIL pre_reset_pulse: got %b expected %b", coin_c, 2'b10);
    end
    RESET = 1'b1;
    tick();
    checks++;
    if ({dir_c, start_c, coin_c} !== 12'hFFF || coin_a !== 2'b00) begin
      errors++; $display("FAIL reset_cuts_pulse: got %h/%b expected %h/%b", {dir_c, start_c, coin_c}, coin_a, 12'hFFF, 2'b00);
    end
    tick(); tick();
    checks++;
    if ({dir_c, start_c, coin_c} !== 12'hFFF) begin
      errors++; $display("FAIL reset_hold_high: got %h expected %h", {dir_c, start_c, coin_c}, 12'hFFF);
    end
    RESET = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if (coin_c[0] !== 1'b0) begin
          errors++; $display("FAIL post_reset_edge: got %b expected %b", coin_c[0], 1'b0);
        end
      end
      if (!coin_c[0]) cnt++;
    end
    checks++;
    if (cnt != 5) begin
      errors++; $display("FAIL post_reset_len: got %0d expected %0d", cnt, 5);
    end
    joy = '0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_key_dir();
    test_socd();
    test_start();
    test_coin_pulse();
    test_no_retrigger();
    test_key_coins();
    test_simultaneous();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
